bus_master: RTL
===============

// Module: bus_master
//
// PURPOSE
//  CPU-side initiator for the memory bus: turns single read/write requests into bus cycles.
//  Drives address/data/bus_enable/write_enable into memory_bus and samples its data_out.
//  Inserts read latency and bus_ready wait states, so slow banks (future SPI ROM/RAM) can
//  stall the CPU. A per-access timeout guarantees the CPU never hangs on a dead bank.
//
// PARAMETERS
//  READ_LATENCY  1    cycles address is held before the first data sample (>=1)
//  TIMEOUT       255  max bus_ready-low cycles before abort; 0 = wait forever
//  TIMEOUT_W     8    width of wait-state counter (must hold TIMEOUT)
//
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  reset        in   1   asynchronous, active-low (0 = reset)
//  req_valid    in   1   CPU request present; held until accepted
//  req_write    in   1   1 = write, 0 = read
//  req_addr     in   16  word address
//  req_wdata    in   16  write data
//  req_ready    out  1   1 = idle and accepting (IDLE state, reset released)
//  rsp_valid    out  1   one-cycle pulse: access finished
//  rsp_rdata    out  16  read data, valid with rsp_valid (0 for writes/timeouts)
//  rsp_timeout  out  1   with rsp_valid: access aborted by TIMEOUT
//  address      out  16  to memory_bus address
//  data_out     out  16  to memory_bus data_in
//  data_in      in   16  from memory_bus data_out
//  bus_enable   out  1   high for the full access, ACCESS..HOLD
//  write_enable out  1   one-cycle write strobe
//  bus_ready    in   1   target ready; tie 1 for zero-wait banks
//
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; address/data_out/rsp_rdata=0; bus_enable,
//   write_enable, rsp_valid, rsp_timeout, req_ready=0. Abort any in-flight access instantly.
//  Counters: lat_cnt (to READ_LATENCY-1), wait_cnt (TIMEOUT_W bits), both cleared on accept.
//  IDLE: req_ready=1. req_valid=1 at edge -> latch addr/wdata/write into address/data_out;
//   bus_enable=1; write_enable=req_write; -> ACCESS. address holds its last value in IDLE.
//  ACCESS (write): write_enable->0 next edge, -> HOLD (address/data stay stable one more
//   cycle because memory_bus registers the strobe).
//  ACCESS (read): while lat_cnt<READ_LATENCY-1, lat_cnt++. Then each edge: bus_ready=1 ->
//   rsp_rdata<=data_in, -> RESP; else wait_cnt++.
//  HOLD (write): bus_ready=1 -> RESP; else wait_cnt++.
//  Timeout: TIMEOUT!=0 and wait_cnt reaches TIMEOUT with bus_ready=0 -> RESP, rsp_timeout=1,
//   rsp_rdata=0. A write already strobed is not retracted.
//  RESP: bus_enable=0, rsp_valid=1 for exactly one cycle, -> IDLE. req_ready=0 in RESP, so
//   back-to-back requests have a 1-cycle gap.
//  Latency from accept edge, zero waits: read = READ_LATENCY+1 edges to rsp_valid; write = 3.
//  req_valid outside IDLE is ignored; req_* changes after acceptance have no effect.
//  bus_ready=1 in the same edge that hits TIMEOUT: ready wins, no timeout.
//  rsp_timeout clears with rsp_valid; write_enable is never high outside ACCESS.
//
// TESTING
//  1 Reset: reset=0 mid-ACCESS with write_enable=1 -> all outputs 0 same cycle; after
//    release req_ready=1, no spurious rsp_valid.
//  2 Read, READ_LATENCY=1, bus_ready=1, addr 16'h2005 where data_in=16'hBEEF ->
//    bus_enable 1 cycle, rsp_valid 2 edges after accept, rsp_rdata=16'hBEEF.
//  3 Write 16'h1234 to 16'h4010 -> write_enable exactly 1 cycle, address/data_out stable
//    2 cycles, rsp_valid at edge 3, rsp_rdata=0.
//  4 Read with bus_ready low 5 cycles then high -> rsp_valid at 2+5 edges, correct data,
//    rsp_timeout=0.
//  5 TIMEOUT=4, bus_ready stuck 0 -> rsp_valid with rsp_timeout=1, rsp_rdata=0, IDLE after.
//  6 Back-to-back: req_valid held high for 3 reads -> each accepted only in IDLE, one
//    rsp_valid per request, in order, with a 1-cycle gap.

Source files
------------

// File: rtl/bus_master.sv
// CPU-side memory bus initiator: one request in, one bus cycle out, one response back.
// Handles read latency, bus_ready wait states and an optional per-access timeout.
//
// state  | meaning
// IDLE   | accepting a request (req_ready=1)
// ACCESS | address driven; write strobe or read latency/sampling
// HOLD   | write: keep address/data stable while the bank registers the strobe
// RESP   | one-cycle rsp_valid pulse, then back to IDLE
module bus_master #(
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 255,
    parameter int TIMEOUT_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic [15:0] address,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    output logic        bus_enable,
    output logic        write_enable,
    input  logic        bus_ready
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0]     LAT_LAST = LAT_W'(READ_LATENCY - 1);
    localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT - 1);
    localparam bit                   TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t               state, state_n;
    logic                 running;
    logic                 is_write, is_write_n;
    logic [LAT_W-1:0]     lat_cnt, lat_cnt_n;
    logic [TIMEOUT_W-1:0] wait_cnt, wait_cnt_n;
    logic [15:0]          address_n, data_out_n, rsp_rdata_n;
    logic                 bus_enable_n, write_enable_n, rsp_valid_n, rsp_timeout_n;
    logic                 wait_expired;

    // running keeps req_ready low until the first edge after reset release
    assign req_ready    = (state == IDLE) && running;
    assign wait_expired = TO_EN && (wait_cnt == TO_LAST);

    always_comb begin
        state_n        = state;
        is_write_n     = is_write;
        lat_cnt_n      = lat_cnt;
        wait_cnt_n     = wait_cnt;
        address_n      = address;
        data_out_n     = data_out;
        rsp_rdata_n    = rsp_rdata;
        bus_enable_n   = bus_enable;
        write_enable_n = 1'b0;
        rsp_valid_n    = 1'b0;
        rsp_timeout_n  = rsp_timeout;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    address_n      = req_addr;
                    data_out_n     = req_wdata;
                    is_write_n     = req_write;
                    bus_enable_n   = 1'b1;
                    write_enable_n = req_write;
                    lat_cnt_n      = '0;
                    wait_cnt_n     = '0;
                    rsp_rdata_n    = '0;
                    rsp_timeout_n  = 1'b0;
                    state_n        = ACCESS;
                end
            end
            ACCESS: begin
                if (is_write) begin
                    state_n = HOLD;
                end else if (lat_cnt < LAT_LAST) begin
                    lat_cnt_n = lat_cnt + LAT_W'(1);
                end else if (bus_ready) begin
                    rsp_rdata_n  = data_in;
                    bus_enable_n = 1'b0;
                    rsp_valid_n  = 1'b1;
                    state_n      = RESP;
                end else if (wait_expired) begin
                    rsp_rdata_n   = '0;
                    rsp_timeout_n = 1'b1;
                    bus_enable_n  = 1'b0;
                    rsp_valid_n   = 1'b1;
                    state_n       = RESP;
                end else begin
                    wait_cnt_n = wait_cnt + TIMEOUT_W'(1);
                end
            end
            HOLD: begin
                if (bus_ready) begin
                    bus_enable_n = 1'b0;
                    rsp_valid_n  = 1'b1;
                    state_n      = RESP;
                end else if (wait_expired) begin
                    // the strobe already went out; only the response reports the abort
                    rsp_rdata_n   = '0;
                    rsp_timeout_n = 1'b1;
                    bus_enable_n  = 1'b0;
                    rsp_valid_n   = 1'b1;
                    state_n       = RESP;
                end else begin
                    wait_cnt_n = wait_cnt + TIMEOUT_W'(1);
                end
            end
            RESP: begin
                rsp_timeout_n = 1'b0;
                state_n       = IDLE;
            end
            default: begin
                bus_enable_n = 1'b0;
                state_n      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            running      <= 1'b0;
            is_write     <= 1'b0;
            lat_cnt      <= '0;
            wait_cnt     <= '0;
            address      <= '0;
            data_out     <= '0;
            rsp_rdata    <= '0;
            bus_enable   <= 1'b0;
            write_enable <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            state        <= state_n;
            running      <= 1'b1;
            is_write     <= is_write_n;
            lat_cnt      <= lat_cnt_n;
            wait_cnt     <= wait_cnt_n;
            address      <= address_n;
            data_out     <= data_out_n;
            rsp_rdata    <= rsp_rdata_n;
            bus_enable   <= bus_enable_n;
            write_enable <= write_enable_n;
            rsp_valid    <= rsp_valid_n;
            rsp_timeout  <= rsp_timeout_n;
        end
    end

endmodule
